dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the data cache; it serves cache refill reads and store writes over a valid/ready request channel with a one-cycle response pulse.
- Writes are absorbed by a small posted-write FIFO and drained to a single-port word array with configurable wait states.
- Reads are forwarded from the FIFO when possible, so the cache always sees coherent data.
- The block sits between the cache and the data memory array.

Parameters:
- ADDR_W, 8: word-index bits; the array depth is 2^ADDR_W, indexed by req_addr[ADDR_W-1:0].
- LAT, 3: memory wait states. Legal range is 2..15.
- WB_DEPTH, 4: posted-write FIFO entries. Must be a power of two, at most 8.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  word address.
- req_wdata  in  16  write data.
- resp_valid  out  1  one-cycle pulse; read data is valid.
- resp_rdata  out  16  read data, held until the next response.
- busy  out  1  state is not IDLE, or the FIFO is non-empty.
- wb_count  out  4  current FIFO occupancy.
- rd_count  out  16  accepted reads, wraps.
- wr_count  out  16  accepted writes, wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE; FIFO emptied; pending posted writes discarded.
  - All outputs go to 0, except req_ready, which is 0 during reset and 1 from the first clock after release.
  - Array contents are not reset. Reset mid-operation aborts with no partial array write.
- States: IDLE, FWD, RD_WAIT, WR_WAIT, with one shared wait counter wcnt.
- req_ready = (state==IDLE) && (wb_count != WB_DEPTH). It is combinational and independent of req_we.
- Accept = req_valid && req_ready.
- Write accept:
  - Push {req_addr, req_wdata} at the FIFO tail and increment wr_count.
  - Stay in IDLE; no response is issued.
  - Duplicate addresses are not merged.
- Read accept:
  - Increment rd_count.
  - Compare the full 16-bit req_addr against all valid FIFO entries.
  - On any match:
    - Latch the data of the youngest matching entry and go to FWD.
    - In the next cycle, resp_valid=1 and resp_rdata=latched data, then return to IDLE.
    - Latency is 1 cycle.
  - On no match:
    - Latch the address and go to RD_WAIT with wcnt=LAT-1.
    - Decrement wcnt each cycle.
    - When wcnt==0, read the array, pulse resp_valid, load resp_rdata, and return to IDLE.
    - resp_valid rises exactly LAT cycles after the accept edge.
- Drain:
  - Condition: state==IDLE, FIFO non-empty, and no accept this cycle.
  - Enter WR_WAIT with wcnt=LAT-1, snapshotting the head entry.
  - When wcnt==0, write the array, pop the head, and return to IDLE.
  - A drain takes LAT cycles. req_ready=0 throughout.
- Full FIFO: req_ready=0, so no accept is possible and a drain starts the next cycle.
- Priority in IDLE: an accepted request beats a drain. A continuous request stream therefore defers draining until the FIFO fills or the stream stalls.
- Ordering: array writes occur in FIFO order. Because of forwarding, a read never returns data older than the latest accepted write to the same address.
- Occupancy and counters:
  - wb_count updates on the edge after a push or pop.
  - Push and pop never occur in the same cycle.
  - Counters wrap from 0xFFFF to 0x0000.
- resp_valid is never high for two consecutive cycles, and never high while state==IDLE on the following edge without a new accept.

Test Plan:
- Read miss: reset, preload mem[0x05]=0xBEEF, read 0x0005 → resp_valid pulses exactly 3 cycles after accept (LAT=3), resp_rdata=0xBEEF, rd_count=1.
- Forwarding: write 0x0010←0x1111, then write 0x0010←0x2222 back-to-back, then read 0x0010 with no idle gap → response 1 cycle after accept with 0x2222, wb_count=2 before any drain.
- Fill and drain: 4 consecutive writes to 0x20..0x23 → req_ready=0 after the 4th, wb_count=4, then 4 drains of 3 cycles each, array holds the data in order, wb_count=0, busy=0.
- Drain/read interaction: a read to 0x30 issued during WR_WAIT → waits for req_ready=1, then a miss response returns the drained value if the address matches, otherwise the array value.
- Reset mid-operation: assert reset during RD_WAIT with 2 writes buffered → resp_valid stays 0, wb_count=0, counters=0, array unchanged at those addresses.
- Wrap: preset rd_count to 0xFFFF via 65535 reads (or a force) → the next read gives rd_count=0x0000.

Source files
------------

// File: rtl/dmem_responder.sv
// Memory-side responder for the data cache: posted-write FIFO with read forwarding,
// draining into a single-port word array with LAT wait states.
//
// state   | meaning
// IDLE    | accepting requests, or starting a drain when no request is taken
// FWD     | read hit in the write FIFO, response issued next edge
// RD_WAIT | read miss, counting down wait states before the array read
// WR_WAIT | draining the FIFO head, counting down before the array write
module dmem_responder #(
    parameter int ADDR_W   = 8,
    parameter int LAT      = 3,
    parameter int WB_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        busy,
    output logic [3:0]  wb_count,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FWD, RD_WAIT, WR_WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [15:0]         fifo_addr_q [WB_DEPTH];
    logic [15:0]         fifo_addr_d [WB_DEPTH];
    logic [15:0]         fifo_data_q [WB_DEPTH];
    logic [15:0]         fifo_data_d [WB_DEPTH];
    logic [15:0]         fwd_data_q, fwd_data_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   dr_addr_q, dr_addr_d;
    logic [15:0]         dr_data_q, dr_data_d;
    logic                resp_valid_q, resp_valid_d;
    logic [15:0]         resp_rdata_q, resp_rdata_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                rdy_en_q;

    logic [15:0]         mem [2**ADDR_W];
    logic                mem_we;
    logic                accept;
    logic                hit;
    logic [15:0]         hit_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == WB_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // rdy_en_q holds req_ready low until the first clock after reset release
    assign req_ready  = rdy_en_q && (state_q == IDLE) && (cnt_q != 4'(WB_DEPTH));
    assign accept     = req_valid && req_ready;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign busy       = (state_q != IDLE) || (cnt_q != 4'd0);
    assign wb_count   = cnt_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

    // Walk entries oldest to youngest so the last match wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((4'(i) < cnt_q) &&
                (fifo_addr_q[PTR_W'((int'(head_q) + i) % WB_DEPTH)] == req_addr)) begin
                hit      = 1'b1;
                hit_data = fifo_data_q[PTR_W'((int'(head_q) + i) % WB_DEPTH)];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        cnt_d        = cnt_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_data_d  = fifo_data_q;
        fwd_data_d   = fwd_data_q;
        rd_addr_d    = rd_addr_q;
        dr_addr_d    = dr_addr_q;
        dr_data_d    = dr_data_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        rd_count_d   = rd_count_q;
        wr_count_d   = wr_count_q;
        mem_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && req_we) begin
                    fifo_addr_d[tail_q] = req_addr;
                    fifo_data_d[tail_q] = req_wdata;
                    tail_d              = ptr_inc(tail_q);
                    cnt_d               = cnt_q + 4'd1;
                    wr_count_d          = wr_count_q + 16'd1;
                end else if (accept) begin
                    rd_count_d = rd_count_q + 16'd1;
                    if (hit) begin
                        fwd_data_d = hit_data;
                        state_d    = FWD;
                    end else begin
                        rd_addr_d = req_addr[ADDR_W-1:0];
                        wcnt_d    = 4'(LAT - 1);
                        state_d   = RD_WAIT;
                    end
                end else if (cnt_q != 4'd0) begin
                    dr_addr_d = fifo_addr_q[head_q][ADDR_W-1:0];
                    dr_data_d = fifo_data_q[head_q];
                    wcnt_d    = 4'(LAT - 1);
                    state_d   = WR_WAIT;
                end
            end
            FWD: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = fwd_data_q;
                state_d      = IDLE;
            end
            RD_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem[rd_addr_q];
                    state_d      = IDLE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            WR_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    mem_we  = 1'b1;
                    head_d  = ptr_inc(head_q);
                    cnt_d   = cnt_q - 4'd1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            cnt_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            fwd_data_q   <= '0;
            rd_addr_q    <= '0;
            dr_addr_q    <= '0;
            dr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            cnt_q        <= cnt_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_data_q  <= fifo_data_d;
            fwd_data_q   <= fwd_data_d;
            rd_addr_q    <= rd_addr_d;
            dr_addr_q    <= dr_addr_d;
            dr_data_q    <= dr_data_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
            rdy_en_q     <= 1'b1;
        end
    end

    // Array is not reset; mem_we is derived from the reset state so an abort never writes
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[dr_addr_q] <= dr_data_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a transaction-timeline
// model: a pending-write queue, a word array and a single "busy for N cycles" timer.
module tb_dmem_responder;

    localparam int ADDR_W   = 8;
    localparam int LAT      = 3;
    localparam int WB_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        busy;
    logic [3:0]  wb_count;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    dmem_responder #(.ADDR_W(ADDR_W), .LAT(LAT), .WB_DEPTH(WB_DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .wb_count   (wb_count),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mm [2**ADDR_W];
    bit          mk [2**ADDR_W];
    logic [15:0] qa [$];
    logic [15:0] qd [$];
    int          m_busy;
    int          m_kind;
    logic [15:0] m_data;
    bit          m_data_known;
    bit          m_ready_en;
    bit          e_resp_valid;
    logic [15:0] e_rdata;
    bit          e_rdata_known;
    logic [15:0] e_rd;
    logic [15:0] e_wr;
    bit          last_acc;

    function automatic bit m_ready();
        return m_ready_en && (m_busy == 0) && (qa.size() < WB_DEPTH);
    endfunction

    task automatic model_reset();
        qa.delete();
        qd.delete();
        m_busy        = 0;
        m_kind        = 0;
        m_ready_en    = 0;
        e_resp_valid  = 0;
        e_rdata       = '0;
        e_rdata_known = 1;
        e_rd          = '0;
        e_wr          = '0;
    endtask

    // Called at a negedge; drives one cycle of stimulus, advances the model, returns at next negedge.
    task automatic step(input bit v, input bit we, input logic [15:0] a, input logic [15:0] d);
        bit acc;
        bit found;
        logic [15:0] fd;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        acc       = v && m_ready();
        last_acc  = acc;
        @(posedge clock);
        e_resp_valid = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                if (m_kind == 0) begin
                    mm[qa[0][ADDR_W-1:0]] = qd[0];
                    mk[qa[0][ADDR_W-1:0]] = 1;
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end else begin
                    e_resp_valid  = 1;
                    e_rdata       = m_data;
                    e_rdata_known = m_data_known;
                end
            end
        end else if (acc && we) begin
            qa.push_back(a);
            qd.push_back(d);
            e_wr++;
        end else if (acc) begin
            e_rd++;
            found = 0;
            fd    = '0;
            for (int i = qa.size() - 1; i >= 0; i--) begin
                if (!found && qa[i] == a) begin
                    found = 1;
                    fd    = qd[i];
                end
            end
            m_kind = 1;
            if (found) begin
                m_busy       = 1;
                m_data       = fd;
                m_data_known = 1;
            end else begin
                m_busy       = LAT;
                m_data       = mm[a[ADDR_W-1:0]];
                m_data_known = mk[a[ADDR_W-1:0]];
            end
        end else if (qa.size() > 0) begin
            m_busy = LAT;
            m_kind = 0;
        end
        m_ready_en = 1;
        @(negedge clock);
        req_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        model_reset();
        reset = 1'b1;
        step(0, 0, 16'h0, 16'h0);
    endtask

    task automatic drain_all();
        int n = 0;
        while ((m_busy != 0 || qa.size() != 0) && n < 200) begin
            step(0, 0, 16'h0, 16'h0);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: busy=%b wb_count=%0d expected idle", busy, wb_count);
        end
    endtask

    // Issues a read, holding it until accepted, then waits for the response; returns latency from accept.
    task automatic do_read(input logic [15:0] a, output int lat, output logic [15:0] data);
        int n = 0;
        lat  = -1;
        data = '0;
        step(1, 0, a, 16'h0);
        while (!last_acc && n < 50) begin
            step(1, 0, a, 16'h0);
            n++;
        end
        n = 1;
        while (resp_valid !== 1'b1 && n < 40) begin
            step(0, 0, 16'h0, 16'h0);
            n++;
        end
        if (resp_valid === 1'b1) begin
            lat  = n - 1;
            data = resp_rdata;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        @(negedge clock);
        checks++;
        if ({resp_valid, req_ready, busy, wb_count, rd_count, wr_count, resp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rv=%b rdy=%b busy=%b wb=%0d rd=%h wr=%h rdata=%h expected all 0",
                     resp_valid, req_ready, busy, wb_count, rd_count, wr_count, resp_rdata);
        end
        model_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_clock: got %b expected 0", req_ready);
        end
        step(0, 0, 16'h0, 16'h0);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_clock: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_read_miss();
        int lat;
        logic [15:0] d;
        do_reset();
        step(1, 1, 16'h0005, 16'hBEEF);
        drain_all();
        model_reset();
        do_reset();
        do_read(16'h0005, lat, d);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL miss_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (d !== 16'hBEEF) begin
            errors++;
            $display("FAIL miss_data: got %h expected beef", d);
        end
        checks++;
        if (rd_count !== 16'd1) begin
            errors++;
            $display("FAIL miss_rd_count: got %0d expected 1", rd_count);
        end
        step(0, 0, 16'h0, 16'h0);
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_pulse_width: resp_valid got %b expected 0", resp_valid);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        step(1, 1, 16'h0010, 16'h1111);
        step(1, 1, 16'h0010, 16'h2222);
        step(1, 0, 16'h0010, 16'h0000);
        checks++;
        if (wb_count !== 4'd2) begin
            errors++;
            $display("FAIL fwd_wb_count: got %0d expected 2", wb_count);
        end
        step(0, 0, 16'h0, 16'h0);
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 16'h2222) begin
            errors++;
            $display("FAIL fwd_resp: valid=%b data=%h expected valid=1 data=2222", resp_valid, resp_rdata);
        end
        drain_all();
    endtask

    task automatic test_fill_drain();
        logic [15:0] wd [4];
        int n;
        int lat;
        logic [15:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wd[i] = 16'($urandom);
            step(1, 1, 16'h0020 + 16'(i), wd[i]);
        end
        checks++;
        if (req_ready !== 1'b0 || wb_count !== 4'd4) begin
            errors++;
            $display("FAIL full_state: ready=%b wb=%0d expected ready=0 wb=4", req_ready, wb_count);
        end
        n = 0;
        while ((wb_count !== 4'd0 || busy !== 1'b0) && n < 60) begin
            step(0, 0, 16'h0, 16'h0);
            n++;
        end
        checks++;
        if (n != 4 * (LAT + 1)) begin
            errors++;
            $display("FAIL drain_cycles: got %0d expected %0d", n, 4 * (LAT + 1));
        end
        for (int i = 0; i < 4; i++) begin
            do_read(16'h0020 + 16'(i), lat, d);
            checks++;
            if (d !== wd[i] || lat != LAT) begin
                errors++;
                $display("FAIL drained_data[%0d]: got %h lat %0d expected %h lat %0d", i, d, lat, wd[i], LAT);
            end
        end
    endtask

    task automatic test_drain_read();
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] d;
        int lat;
        do_reset();
        x = 16'($urandom);
        y = 16'($urandom);
        step(1, 1, 16'h0030, x);
        step(0, 0, 16'h0, 16'h0);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_drain: got %b expected 0", req_ready);
        end
        do_read(16'h0030, lat, d);
        checks++;
        if (d !== x || lat != LAT) begin
            errors++;
            $display("FAIL read_after_drain: got %h lat %0d expected %h lat %0d", d, lat, x, LAT);
        end
        step(1, 1, 16'h0031, y);
        step(0, 0, 16'h0, 16'h0);
        do_read(16'h0030, lat, d);
        checks++;
        if (d !== x || lat != LAT) begin
            errors++;
            $display("FAIL read_other_during_drain: got %h lat %0d expected %h lat %0d", d, lat, x, LAT);
        end
        drain_all();
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        int lat;
        do_reset();
        step(1, 1, 16'h0050, 16'hA050);
        step(1, 1, 16'h0051, 16'hA051);
        drain_all();
        step(1, 1, 16'h0050, 16'h5555);
        step(1, 1, 16'h0051, 16'h6666);
        step(1, 0, 16'h0052, 16'h0000);
        step(0, 0, 16'h0, 16'h0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({resp_valid, busy, wb_count, rd_count, wr_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid: rv=%b busy=%b wb=%0d rd=%h wr=%h expected all 0",
                     resp_valid, busy, wb_count, rd_count, wr_count);
        end
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_resp: got %b expected 0", resp_valid);
            end
        end
        reset = 1'b1;
        step(0, 0, 16'h0, 16'h0);
        do_read(16'h0050, lat, d);
        checks++;
        if (d !== 16'hA050) begin
            errors++;
            $display("FAIL reset_array_50: got %h expected a050", d);
        end
        do_read(16'h0051, lat, d);
        checks++;
        if (d !== 16'hA051) begin
            errors++;
            $display("FAIL reset_array_51: got %h expected a051", d);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.rd_count_q = 16'hFFFF;
        #1;
        release dut.rd_count_q;
        e_rd = 16'hFFFF;
        step(1, 0, 16'h0060, 16'h0000);
        checks++;
        if (rd_count !== 16'h0000) begin
            errors++;
            $display("FAIL rd_count_wrap: got %h expected 0000", rd_count);
        end
        drain_all();
    endtask

    task automatic test_random();
        logic [15:0] pool [6];
        logic [15:0] a;
        bit v;
        bit we;
        pool[0] = 16'h0070;
        pool[1] = 16'h0071;
        pool[2] = 16'h0072;
        pool[3] = 16'h0073;
        pool[4] = 16'h0170;
        pool[5] = 16'h8071;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            v  = ($urandom_range(0, 99) < 60);
            we = ($urandom_range(0, 1) == 1);
            a  = pool[$urandom_range(0, 5)];
            checks++;
            if (req_ready !== m_ready()) begin
                errors++;
                $display("FAIL rnd_ready cyc %0d: got %b expected %b", c, req_ready, m_ready());
            end
            step(v, we, a, 16'($urandom));
            checks++;
            if (resp_valid !== e_resp_valid) begin
                errors++;
                $display("FAIL rnd_resp_valid cyc %0d: got %b expected %b", c, resp_valid, e_resp_valid);
            end
            if (e_rdata_known) begin
                checks++;
                if (resp_rdata !== e_rdata) begin
                    errors++;
                    $display("FAIL rnd_rdata cyc %0d: got %h expected %h", c, resp_rdata, e_rdata);
                end
            end
            checks++;
            if (wb_count !== 4'(qa.size()) || busy !== (m_busy > 0 || qa.size() > 0)) begin
                errors++;
                $display("FAIL rnd_occupancy cyc %0d: wb=%0d busy=%b expected wb=%0d busy=%b",
                         c, wb_count, busy, qa.size(), (m_busy > 0 || qa.size() > 0));
            end
            checks++;
            if (rd_count !== e_rd || wr_count !== e_wr) begin
                errors++;
                $display("FAIL rnd_counters cyc %0d: rd=%h wr=%h expected rd=%h wr=%h",
                         c, rd_count, wr_count, e_rd, e_wr);
            end
        end
        drain_all();
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            mm[i] = '0;
            mk[i] = 0;
        end
        model_reset();
        test_reset();
        test_read_miss();
        test_forwarding();
        test_fill_drain();
        test_drain_read();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
